// File: rtl/sha_pkg.sv
// Shared types and constants for the SHA-256 message loader.
package sha_pkg;

    localparam int SHA_WORD_W = 32;
    localparam int SHA_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_FLUSH,
        ST_START,
        ST_WAIT,
        ST_DONE
    } loader_state_e;

    function automatic int bytes_per_msg(input int n);
        return 4 * n;
    endfunction

endpackage

// File: rtl/sha_byte_packer.sv
// Packs bytes into 32-bit words; big-endian by default, LSB-first when
// SHA_LOADER_LE_EN is defined. Unfilled lanes stay zero, so pad is free.
module sha_byte_packer
    import sha_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  byte_en,
    input  logic [7:0]            byte_data,
    input  logic                  pad,
    output logic [1:0]            lane,
    output logic                  word_valid,
    output logic [SHA_WORD_W-1:0] word_data
);

    logic [SHA_WORD_W-1:0] acc;
    logic [SHA_WORD_W-1:0] merged;

    always_comb begin
        merged = acc;
`ifdef SHA_LOADER_LE_EN
        case (lane)
            2'd0:    merged[7:0]   = byte_data;
            2'd1:    merged[15:8]  = byte_data;
            2'd2:    merged[23:16] = byte_data;
            default: merged[31:24] = byte_data;
        endcase
`else
        case (lane)
            2'd0:    merged[31:24] = byte_data;
            2'd1:    merged[23:16] = byte_data;
            2'd2:    merged[15:8]  = byte_data;
            default: merged[7:0]   = byte_data;
        endcase
`endif
    end

    // A padded word completes early; the accumulator is always cleared afterwards.
    assign word_valid = byte_en && ((lane == 2'd3) || pad);
    assign word_data  = merged;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc  <= '0;
            lane <= 2'd0;
        end else if (clr || word_valid) begin
            acc  <= '0;
            lane <= 2'd0;
        end else if (byte_en) begin
            acc  <= merged;
            lane <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/sha256_msg_loader.sv
// Byte-stream to message-memory loader that then starts the SHA-256 core.
// Byte packing order is selected by SHA_LOADER_LE_EN (see sha_byte_packer).
// in_valid/in_ready: a byte transfers on a rising clk edge where both are high;
// in_ready depends only on state, never on in_valid.
module sha256_msg_loader
    import sha_pkg::*;
#(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [SHA_ADDR_W-1:0] base_addr,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [SHA_ADDR_W-1:0] mem_addr,
    output logic [SHA_WORD_W-1:0] mem_write_data,
    output logic                  core_start,
    input  logic                  core_done,
    output logic                  busy,
    output logic                  hash_done,
    output logic                  short_msg,
    output loader_state_e         dbg_state
);

    localparam logic [9:0] LAST_IDX = 10'(NUM_OF_WORDS - 1);

    loader_state_e         state, next_state;
    logic [9:0]            word_idx;
    logic [SHA_ADDR_W-1:0] addr_ptr;
    logic                  seen_low;
    logic                  byte_en, pad, wr, set_short;
    logic [SHA_WORD_W-1:0] wr_data;
    logic [1:0]            pk_lane;
    logic                  pk_valid;
    logic [SHA_WORD_W-1:0] pk_word;

    assign dbg_state = state;

    sha_byte_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr        (state == ST_IDLE),
        .byte_en    (byte_en),
        .byte_data  (in_data),
        .pad        (pad),
        .lane       (pk_lane),
        .word_valid (pk_valid),
        .word_data  (pk_word)
    );

    always_comb begin
        next_state = state;
        byte_en    = 1'b0;
        pad        = 1'b0;
        wr         = 1'b0;
        wr_data    = '0;
        set_short  = 1'b0;
        case (state)
            ST_IDLE: if (load) next_state = ST_FILL;
            ST_FILL: begin
                byte_en = in_valid && in_ready;
                pad     = byte_en && in_last;
                if (pk_valid) begin
                    wr      = 1'b1;
                    wr_data = pk_word;
                    if (word_idx == LAST_IDX) next_state = ST_START;
                    else if (in_last)         next_state = ST_FLUSH;
                end
                // Only a last byte that exactly completes the final word is a normal end.
                set_short = pad && !((word_idx == LAST_IDX) && (pk_lane == 2'd3));
            end
            ST_FLUSH: begin
                wr = 1'b1;
                if (word_idx == LAST_IDX) next_state = ST_START;
            end
            ST_START: next_state = ST_WAIT;
            ST_WAIT:  if (seen_low && core_done) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            in_ready       <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            core_start     <= 1'b0;
            busy           <= 1'b0;
            hash_done      <= 1'b0;
            short_msg      <= 1'b0;
            word_idx       <= '0;
            addr_ptr       <= '0;
            seen_low       <= 1'b0;
        end else begin
            state      <= next_state;
            in_ready   <= (next_state == ST_FILL);
            // Keep the port through the final write, which lands in the START cycle.
            mem_req    <= (next_state == ST_FILL) || (next_state == ST_FLUSH) || wr;
            mem_we     <= wr;
            core_start <= (state == ST_START);
            busy       <= (next_state != ST_IDLE);
            hash_done  <= (next_state == ST_DONE);
            seen_low   <= (state == ST_WAIT) && (seen_low || !core_done);
            if (wr) begin
                mem_addr       <= addr_ptr;
                mem_write_data <= wr_data;
            end
            if (state == ST_IDLE && load) begin
                addr_ptr  <= base_addr;
                word_idx  <= '0;
                short_msg <= 1'b0;
            end else begin
                if (wr) begin
                    addr_ptr <= addr_ptr + 16'd1;
                    word_idx <= word_idx + 10'd1;
                end
                if (set_short) short_msg <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sha256_msg_loader.md
# sha256_msg_loader

Upstream feeder for the SHA-256 core. Accepts a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words. Writes exactly NUM_OF_WORDS words into shared message memory starting at base_addr, then pulses the core's start and waits for its done. While loading it owns the memory port (mem_req=1); the top level muxes loader and core memory signals on mem_req.

## Interface
- NUM_OF_WORDS, 20: message length in 32-bit words; must match the core's NUM_OF_WORDS; legal 1..1023.
- clk  in  1  clock; also drives the memory.
- reset_n  in  1  asynchronous, active-low reset.
- load  in  1  begin a load; sampled only in IDLE.
- base_addr  in  16  word address of the first message word; sampled with load.
- in_valid  in  1  byte available.
- in_data  in  8  message byte.
- in_last  in  1  marks the final byte; qualified by in_valid.
- in_ready  out  1  loader accepts a byte this cycle.
- mem_req  out  1  loader owns the memory port.
- mem_we  out  1  write strobe.
- mem_addr  out  16  word write address.
- mem_write_data  out  32  word written.
- core_start  out  1  one-cycle start pulse to the SHA core.
- core_done  in  1  core done; level signal, high while the core is idle.
- busy  out  1  high in every state except IDLE.
- hash_done  out  1  one-cycle pulse when the core has finished.
- short_msg  out  1  high when in_last arrived before 4*NUM_OF_WORDS bytes; held until the next load.

## Operation
- States: IDLE, FILL, FLUSH, START, WAIT, DONE.
- IDLE:
  - On load=1, latch base_addr and clear the byte and word counters and short_msg.
  - Next state is FILL; mem_req goes to 1.
- FILL:
  - in_ready=1; a byte transfers when in_valid && in_ready.
  - Bytes shift into the word accumulator MSB-first: the first byte goes to [31:24].
  - On the 4th byte of a word, the packed word is written at base_addr+word_idx and word_idx increments.
- End of FILL:
  - If the accepted byte completes word NUM_OF_WORDS-1, go to START. An in_last on that byte is the normal end and does not set short_msg.
  - If in_last is accepted earlier, zero-pad the current partial word, write it, set short_msg, and go to FLUSH. If in_last lands on a word boundary, just go to FLUSH.
- FLUSH: write 32'h0 once per cycle at successive addresses until NUM_OF_WORDS words have been written in total, then go to START.
- START: core_start=1 for exactly one cycle; mem_req drops to 0; go to WAIT.
- WAIT:
  - First wait for core_done=0 (the core has left its idle state).
  - Then wait for core_done=1; go to DONE.
- DONE: hash_done=1 for one cycle; go to IDLE.
- load outside IDLE is ignored. in_valid outside FILL is ignored (in_ready=0).
- Address arithmetic: 16-bit, wraps modulo 2^16 with no error.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_write_data=0, core_start=0, busy=0, hash_done=0, short_msg=0.
- load sampled in cycle N: in_ready=1 in cycle N+1.
- 4th byte of a word accepted in cycle M: mem_we=1 with that address and data in cycle M+1, held for one cycle.
- Throughput: one byte per cycle sustained, with no bubbles between words.
- FLUSH: one word per cycle.
- The last write is followed by core_start one cycle later.
- core_done rises in cycle D: hash_done=1 in cycle D+1.
- Reset mid-operation: return to IDLE immediately; no further writes; partially written memory is left as is.

## Configuration
- SHA_LOADER_LE_EN:
  - Defined: bytes pack LSB-first (first byte goes to [7:0]). Zero-padding of a partial word fills the unfilled upper bytes.
  - Undefined: big-endian packing as above.
  - Only the packing changes; all other behaviour is identical.

## Structure
- Package sha_pkg:
  - loader state enum.
  - SHA_WORD_W=32, SHA_ADDR_W=16.
  - helper function bytes_per_msg(n)=4*n.
- Sub-module sha_byte_packer:
  - Byte accumulator with 2-bit lane counter, pad-on-flush input and word_valid output.
  - Holds the SHA_LOADER_LE_EN ifdef.

## Test plan
- NUM_OF_WORDS=20, base_addr=16'h0000, 80 bytes 0x00..0x4F with in_valid continuous and in_last on byte 79 -> 20 writes; word 0 = 32'h00010203, word 19 = 32'h4C4D4E4F at address 19; short_msg=0; core_start one cycle after the final write.
- Same stream with in_valid toggling every other cycle -> identical memory contents, and in_ready never high outside FILL.
- in_last on byte 5 (bytes 0xA0..0xA5), base 16'h0100 -> 0x0100=32'hA0A1A2A3, 0x0101=32'hA4A50000, 0x0102..0x0113=0; short_msg=1.
- Core model drops core_done 1 cycle after start and raises it 150 cycles later -> hash_done exactly one cycle after the rise; busy=0 the next cycle; no early hash_done while core_done is still high from idle.
- base_addr=16'hFFFE, 20 words -> writes at FFFE, FFFF, 0000..0011.
- reset_n asserted after 10 bytes -> all outputs at reset values within the same cycle; a new load then restarts at word 0.
- With SHA_LOADER_LE_EN defined, test 1 -> word 0 = 32'h03020100.
